bitstream_self_write_loader: RTL and testbench

//  Synthesizable successor to the bench-side bitstream load loop. Reads a byte-wide bitstream

---
 rtl/bitstream_self_write_loader_if.sv | 17 +
 rtl/bitstream_self_write_loader.sv | 278 +++++++++++++++++++++++++++
 tb/tb_bitstream_self_write_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitstream_self_write_loader_if.sv
// Bundles the byte-wide image-memory read port and the fabric config-write port.
// master: loader side; slave: memory/fabric side.
interface bitstream_self_write_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_data;
  logic [DATA_WIDTH-1:0] SelfWriteData;
  logic                  SelfWriteStrobe;

  modport master (output mem_rd, output mem_addr, input mem_data,
                  output SelfWriteData, output SelfWriteStrobe);
  modport slave  (input mem_rd, input mem_addr, output mem_data,
                  input SelfWriteData, input SelfWriteStrobe);
endinterface

// File: rtl/bitstream_self_write_loader.sv
// Boot-from-ROM bitstream loader: fetches bytes, packs config words, drives SelfWrite port.
// Optional macro BITSTREAM_CRC_EN adds a CRC-32 (MPEG-2 style) over every strobed word.
module bitstream_self_write_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int SETUP_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int BIG_ENDIAN   = 1
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ADDR_WIDTH:0]          byte_count,
  bitstream_self_write_loader_if.master bus,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH:0]          words_written
`ifdef BITSTREAM_CRC_EN
  ,
  output logic [31:0]                  crc32
`endif
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int IW1 = IW + 1;
  localparam logic [ADDR_WIDTH:0] ONE_A     = AW1'(1);
  localparam logic [IW:0]         ONE_I     = IW1'(1);
  localparam logic [ADDR_WIDTH:0] BPW_C     = AW1'(BPW);
  localparam logic [ADDR_WIDTH:0] MAX_BYTES = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d, remaining_q, remaining_d, words_q, words_d;
  logic [IW:0]           rd_left_q, rd_left_d, cap_idx_q, cap_idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d, swd_q, swd_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  rd_dly_q, rd_dly_d, mem_rd_q, mem_rd_d, strobe_q, strobe_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  launch_s;
  logic [ADDR_WIDTH:0]   f_rem_s, f_addr_s, len_s;
`ifdef BITSTREAM_CRC_EN
  logic [31:0]           crc_q, crc_d;

  function automatic logic [31:0] crc32_word(input logic [31:0] crc_in,
                                             input logic [DATA_WIDTH-1:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0000_0000);
    end
    return c;
  endfunction
`endif

  // Byte k of a word lands at the MSByte end under big-endian packing, LSByte end otherwise.
  function automatic logic [DATA_WIDTH-1:0] place_byte(input logic [7:0] b, input logic [IW:0] idx);
    logic [DATA_WIDTH-1:0] w;
    w      = '0;
    w[7:0] = b;
    return (BIG_ENDIAN != 0) ? (w << (8 * (BPW - 1 - int'(idx)))) : (w << (8 * int'(idx)));
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    rd_left_d   = rd_left_q;
    cap_idx_d   = cap_idx_q;
    word_d      = word_q;
    rd_dly_d    = mem_rd_q;
    cnt_d       = cnt_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    swd_d       = swd_q;
    strobe_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    words_d     = words_q;
`ifdef BITSTREAM_CRC_EN
    crc_d       = crc_q;
`endif
    launch_s    = 1'b0;
    f_rem_s     = remaining_q;
    f_addr_s    = addr_q;
    len_s       = (byte_count > MAX_BYTES) ? MAX_BYTES : byte_count;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          words_d     = '0;
          addr_d      = '0;
          remaining_d = len_s;
`ifdef BITSTREAM_CRC_EN
          crc_d       = 32'hFFFF_FFFF;
`endif
          if (len_s == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            done_d   = 1'b0;
            busy_d   = 1'b1;
            launch_s = 1'b1;
            f_rem_s  = len_s;
            f_addr_s = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (mem_rd_q && (rd_left_q != '0)) begin
          mem_rd_d    = 1'b1;
          mem_addr_d  = addr_q[ADDR_WIDTH-1:0];
          addr_d      = addr_q + ONE_A;
          remaining_d = remaining_q - ONE_A;
          rd_left_d   = rd_left_q - ONE_I;
        end else begin
          mem_rd_d = 1'b0;
        end
        // Read data is valid the cycle after its read; the last capture ends the fetch.
        if (rd_dly_q) begin
          word_d    = word_q | place_byte(bus.mem_data, cap_idx_q);
          cap_idx_d = cap_idx_q + ONE_I;
          if (!mem_rd_q) begin
            state_d = S_SETUP;
            swd_d   = word_d;
            cnt_d   = 16'(SETUP_CYCLES - 1);
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          word_d = word_q;
        end
      end
      S_SETUP: begin
        if (cnt_q == 16'd0) begin
          state_d  = S_STROBE;
          strobe_d = 1'b1;
          words_d  = words_q + ONE_A;
`ifdef BITSTREAM_CRC_EN
          crc_d    = crc32_word(crc_q, swd_q);
`endif
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STROBE: begin
        if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          cnt_d   = 16'(GAP_CYCLES - 1);
        end else if (remaining_q != '0) begin
          launch_s = 1'b1;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (remaining_q != '0) begin
          launch_s = 1'b1;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // First read of a word is issued on the edge that enters FETCH.
    if (launch_s) begin
      state_d     = S_FETCH;
      mem_rd_d    = 1'b1;
      mem_addr_d  = f_addr_s[ADDR_WIDTH-1:0];
      addr_d      = f_addr_s + ONE_A;
      remaining_d = f_rem_s - ONE_A;
      rd_left_d   = (f_rem_s >= BPW_C) ? IW1'(BPW - 1) : IW1'(f_rem_s - ONE_A);
      word_d      = '0;
      cap_idx_d   = '0;
    end else begin
      rd_left_d = rd_left_d;
    end

    if (abort && busy_q) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      mem_rd_d = 1'b0;
      strobe_d = 1'b0;
      words_d  = words_q;
`ifdef BITSTREAM_CRC_EN
      crc_d    = crc_q;
`endif
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      rd_left_q   <= '0;
      cap_idx_q   <= '0;
      word_q      <= '0;
      rd_dly_q    <= 1'b0;
      cnt_q       <= 16'd0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      swd_q       <= '0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      words_q     <= '0;
`ifdef BITSTREAM_CRC_EN
      crc_q       <= 32'hFFFF_FFFF;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      rd_left_q   <= rd_left_d;
      cap_idx_q   <= cap_idx_d;
      word_q      <= word_d;
      rd_dly_q    <= rd_dly_d;
      cnt_q       <= cnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      swd_q       <= swd_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      words_q     <= words_d;
`ifdef BITSTREAM_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign bus.mem_rd          = mem_rd_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.SelfWriteData   = swd_q;
  assign bus.SelfWriteStrobe = strobe_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign words_written       = words_q;
`ifdef BITSTREAM_CRC_EN
  assign crc32               = crc_q;
`endif
endmodule

// File: tb/tb_bitstream_self_write_loader.sv
// Directed bench: big-endian loader (a, 14-bit address) and little-endian loader
// (b, 4-bit address for the clamp case) fed by small synchronous ROM models.
module tb_bitstream_self_write_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, abort_a, busy_a, done_a;
  logic [14:0] bc_a, ww_a;
  logic        start_b, abort_b, busy_b, done_b;
  logic [4:0]  bc_b, ww_b;
`ifdef BITSTREAM_CRC_EN
  logic [31:0] crc_a, crc_b;
`endif

  bitstream_self_write_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) if_a ();
  bitstream_self_write_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  if_b ();

  bitstream_self_write_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .SETUP_CYCLES(2),
                                .GAP_CYCLES(2), .BIG_ENDIAN(1)) u_a (
    .CLK(clk), .rst(rst), .start(start_a), .abort(abort_a), .byte_count(bc_a),
    .bus(if_a), .busy(busy_a), .done(done_a), .words_written(ww_a)
`ifdef BITSTREAM_CRC_EN
    , .crc32(crc_a)
`endif
  );

  bitstream_self_write_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .SETUP_CYCLES(2),
                                .GAP_CYCLES(2), .BIG_ENDIAN(0)) u_b (
    .CLK(clk), .rst(rst), .start(start_b), .abort(abort_b), .byte_count(bc_b),
    .bus(if_b), .busy(busy_b), .done(done_b), .words_written(ww_b)
`ifdef BITSTREAM_CRC_EN
    , .crc32(crc_b)
`endif
  );

  // ROM models: a uses a writable table, b returns address+1.
  logic [7:0] rom_a [16];
  always @(posedge clk) if (if_a.mem_rd) if_a.mem_data <= rom_a[if_a.mem_addr[3:0]];
  always @(posedge clk) if (if_b.mem_rd) if_b.mem_data <= 8'(if_b.mem_addr) + 8'd1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sw_a[$], sw_b[$];
  int          sc_a[$];
  int          rd_a = 0, rd_b = 0;
  logic [3:0]  last_addr_b = 4'd0;
  always @(negedge clk) begin
    if (if_a.SelfWriteStrobe) begin
      sw_a.push_back(if_a.SelfWriteData);
      sc_a.push_back(cyc);
    end
    if (if_a.mem_rd) rd_a++;
    if (if_b.SelfWriteStrobe) sw_b.push_back(if_b.SelfWriteData);
    if (if_b.mem_rd) begin
      rd_b++;
      last_addr_b = if_b.mem_addr;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] qa(input int i);
    return (i < sw_a.size()) ? 64'(sw_a[i]) : {64{1'bx}};
  endfunction

  function automatic logic [63:0] qb(input int i);
    return (i < sw_b.size()) ? 64'(sw_b[i]) : {64{1'bx}};
  endfunction

  task automatic pulse_a();
    start_a = 1'b1; tick(1); start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1; tick(1); start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input string tag);
    int n = 0;
    while (!(sel_b ? done_b : done_a) && n < 300) begin tick(1); n++; end
    chk(tag, 64'(sel_b ? done_b : done_a), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   64'(busy_a),               64'd0);
    chk({tag, "_done"},   64'(done_a),               64'd0);
    chk({tag, "_ww"},     64'(ww_a),                 64'd0);
    chk({tag, "_rd"},     64'(if_a.mem_rd),          64'd0);
    chk({tag, "_addr"},   64'(if_a.mem_addr),        64'd0);
    chk({tag, "_data"},   64'(if_a.SelfWriteData),   64'd0);
    chk({tag, "_strobe"}, 64'(if_a.SelfWriteStrobe), 64'd0);
  endtask

  int base, r0, n;

  initial begin
    for (int i = 0; i < 16; i++) rom_a[i] = 8'(i + 1);
    rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; bc_a = 15'd0;
    start_b = 1'b0; abort_b = 1'b0; bc_b = 5'd0;
    tick(3);
    chk_idle_outputs("reset");
    chk("reset_b_done", 64'(done_b), 64'd0);
`ifdef BITSTREAM_CRC_EN
    chk("reset_crc", 64'(crc_b), 64'hFFFF_FFFF);
`endif
    rst = 1'b0;
    tick(1);

    // 8-byte big-endian load; a second start mid-load must be ignored.
    bc_a = 15'd8; base = sw_a.size(); r0 = rd_a;
    pulse_a();
    chk("t1_busy", 64'(busy_a), 64'd1);
    tick(3);
    bc_a = 15'd4;
    pulse_a();
    wait_done(1'b0, "t1_done");
    chk("t1_nstrobe", 64'(sw_a.size() - base), 64'd2);
    chk("t1_w0", qa(base), 64'h0102_0304);
    chk("t1_w1", qa(base + 1), 64'h0506_0708);
    chk("t1_spacing", (sw_a.size() - base == 2) ? 64'(sc_a[base + 1] - sc_a[base]) : {64{1'bx}}, 64'd10);
    chk("t1_ww", 64'(ww_a), 64'd2);
    chk("t1_busy_end", 64'(busy_a), 64'd0);
    chk("t1_reads", 64'(rd_a - r0), 64'd8);

    // DONE returns to IDLE on start; then a 6-byte load with zero padding.
    pulse_a();
    chk("t3_done_clr", 64'(done_a), 64'd0);
    bc_a = 15'd6; base = sw_a.size(); r0 = rd_a;
    pulse_a();
    wait_done(1'b0, "t3_done");
    chk("t3_w0", qa(base), 64'h0102_0304);
    chk("t3_w1", qa(base + 1), 64'h0506_0000);
    chk("t3_reads", 64'(rd_a - r0), 64'd6);
    chk("t3_ww", 64'(ww_a), 64'd2);

    // Zero-length image: done the cycle after start, nothing read or written.
    pulse_a();
    bc_a = 15'd0; base = sw_a.size(); r0 = rd_a;
    pulse_a();
    chk("t4_done", 64'(done_a), 64'd1);
    chk("t4_busy", 64'(busy_a), 64'd0);
    tick(3);
    chk("t4_nstrobe", 64'(sw_a.size() - base), 64'd0);
    chk("t4_reads", 64'(rd_a - r0), 64'd0);
    chk("t4_ww", 64'(ww_a), 64'd0);

    // Abort during the second word's setup, then a full reload.
    pulse_a();
    bc_a = 15'd8; base = sw_a.size(); r0 = rd_a;
    pulse_a();
    n = 0;
    while (if_a.SelfWriteData !== 32'h0506_0708 && n < 100) begin tick(1); n++; end
    chk("t5_reach_setup", 64'(if_a.SelfWriteData), 64'h0506_0708);
    abort_a = 1'b1; tick(1); abort_a = 1'b0;
    chk("t5_busy", 64'(busy_a), 64'd0);
    chk("t5_done", 64'(done_a), 64'd0);
    chk("t5_ww", 64'(ww_a), 64'd1);
    tick(20);
    chk("t5_nstrobe", 64'(sw_a.size() - base), 64'd1);
    chk("t5_ww_hold", 64'(ww_a), 64'd1);
    base = sw_a.size();
    pulse_a();
    wait_done(1'b0, "t5_reload_done");
    chk("t5_reload_w0", qa(base), 64'h0102_0304);
    chk("t5_reload_w1", qa(base + 1), 64'h0506_0708);
    chk("t5_reload_ww", 64'(ww_a), 64'd2);

    // Reset in the middle of a load clears every output.
    pulse_a();
    pulse_a();
    n = 0;
    while (ww_a != 15'd1 && n < 100) begin tick(1); n++; end
    chk("t5_rst_progress", 64'(ww_a), 64'd1);
    tick(2);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk_idle_outputs("t5_rst");

    // start together with abort in IDLE: abort wins.
    r0 = rd_a;
    start_a = 1'b1; abort_a = 1'b1; tick(1); start_a = 1'b0; abort_a = 1'b0;
    chk("sa_busy", 64'(busy_a), 64'd0);
    tick(5);
    chk("sa_reads", 64'(rd_a - r0), 64'd0);

    // Little-endian packing on loader b.
    bc_b = 5'd8; base = sw_b.size();
    pulse_b();
    wait_done(1'b1, "t2_done");
    chk("t2_w0", qb(base), 64'h0403_0201);
    chk("t2_w1", qb(base + 1), 64'h0807_0605);
    chk("t2_ww", 64'(ww_b), 64'd2);
    chk("t2_busy", 64'(busy_b), 64'd0);

    // Oversized count clamps to the 16-byte address space without wrapping.
    pulse_b();
    bc_b = 5'd31; base = sw_b.size(); r0 = rd_b;
    pulse_b();
    wait_done(1'b1, "clamp_done");
    chk("clamp_nstrobe", 64'(sw_b.size() - base), 64'd4);
    chk("clamp_w0", qb(base), 64'h0403_0201);
    chk("clamp_w3", qb(base + 3), 64'h100F_0E0D);
    chk("clamp_reads", 64'(rd_b - r0), 64'd16);
    chk("clamp_last_addr", 64'(last_addr_b), 64'd15);
    chk("clamp_ww", 64'(ww_b), 64'd4);

`ifdef BITSTREAM_CRC_EN
    // CRC over a single all-zero word.
    for (int i = 0; i < 4; i++) rom_a[i] = 8'h00;
    bc_a = 15'd4; base = sw_a.size();
    pulse_a();
    chk("crc_init", 64'(crc_a), 64'hFFFF_FFFF);
    wait_done(1'b0, "crc_done");
    chk("crc_word", qa(base), 64'h0);
    chk("crc_value", 64'(crc_a), 64'hC704_DD7B);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
